serial_word_collector: RTL and testbench

Downstream stage of the universal shift register. Accepts the serial bit stream the register shifts out (SISO/PISO modes) and reassembles DW-bit parallel words in MSB-first or LSB-first order. Completed words go into a 2-entry output FIFO that is read through a valid/ready handshake. When the FIFO is full, backpressure is applied to the serial side on the last bit of a word.

---
 rtl/serial_word_collector_if.sv | 22 ++
 rtl/serial_word_collector.sv | 96 +++++++++
 tb/tb_serial_word_collector.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_collector_if.sv
// Serial-in / word-out handshake bundle for serial_word_collector.
// The slave modport is the collector; the master modport is the bit producer plus the word consumer.
interface serial_word_collector_if #(
    parameter int unsigned DW = 4
) ();
    logic          ser_in;
    logic          ser_vld;
    logic          ser_rdy;
    logic [DW-1:0] word_out;
    logic          word_vld;
    logic          word_rdy;

    modport master (
        output ser_in, ser_vld, word_rdy,
        input  ser_rdy, word_out, word_vld
    );

    modport slave (
        input  ser_in, ser_vld, word_rdy,
        output ser_rdy, word_out, word_vld
    );
endinterface

// File: rtl/serial_word_collector.sv
// Reassembles a serial bit stream into DW-bit words (MSB- or LSB-first) and queues them in a
// 2-entry FIFO. When the FIFO is full, the last bit of a word is held off.
module serial_word_collector #(
    parameter int unsigned DW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  clr,
    input  logic                  lsb_first,
    output logic                  busy,
    serial_word_collector_if.slave bus
);
    localparam int unsigned CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] shreg, shreg_nxt, word_asm;
    logic [1:0]    fifo_cnt, fifo_cnt_nxt;
    logic [DW-1:0] mem [2];
    logic          rd_ptr, wr_ptr;
    logic          ser_rdy_c, accept, push, pop;

    // Handshake and datapath decode
    always_comb begin
        word_asm  = lsb_first ? {bus.ser_in, shreg[DW-1:1]} : {shreg[DW-2:0], bus.ser_in};
        ser_rdy_c = enb && (state != WAIT);
        accept    = enb && bus.ser_vld && ser_rdy_c && !clr;
        push      = accept && (cnt == LAST);
        pop       = (fifo_cnt != 2'd0) && bus.word_rdy;
    end

    assign bus.ser_rdy  = ser_rdy_c;
    assign bus.word_vld = (fifo_cnt != 2'd0);
    assign bus.word_out = mem[rd_ptr];
    assign busy         = (cnt != '0);

    // Next-state: counter, shifter, FIFO occupancy and FSM state
    always_comb begin
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        fifo_cnt_nxt = fifo_cnt;
        state_nxt    = state;

        if (clr) begin
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else if (accept) begin
            shreg_nxt = word_asm;
            cnt_nxt   = push ? '0 : cnt + CW'(1);
        end

        if (push && !pop) begin
            fifo_cnt_nxt = fifo_cnt + 2'd1;
        end else if (pop && !push) begin
            fifo_cnt_nxt = fifo_cnt - 2'd1;
        end

        // A word stalls on its last bit only while both FIFO slots are occupied
        if (cnt_nxt == '0) begin
            state_nxt = IDLE;
        end else if ((cnt_nxt == LAST) && (fifo_cnt_nxt == 2'd2)) begin
            state_nxt = WAIT;
        end else begin
            state_nxt = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            fifo_cnt <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            fifo_cnt <= fifo_cnt_nxt;
            if (push) begin
                mem[wr_ptr] <= word_asm;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of bits in flight and stored words.
module tb_serial_word_collector;
    localparam int unsigned DW = 4;

    logic clk = 1'b0;
    logic rst, enb, clr, lsb_first, busy;

    serial_word_collector_if #(.DW(DW)) bus ();

    serial_word_collector #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .clr       (clr),
        .lsb_first (lsb_first),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 1'b0;

    // Model: bits of the word being collected, words waiting for the consumer, and a pop log
    bit            mbits [$];
    logic [DW-1:0] mq [$];
    logic [DW-1:0] popped [$];
    bit            m_acc, m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy();
        return enb && !((mbits.size() == DW - 1) && (mq.size() == 2));
    endfunction

    // Bit i of the stream lands at position i (LSB-first) or DW-1-i (MSB-first)
    function automatic logic [DW-1:0] assemble(input bit lsb);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < int'(DW); i++) begin
            w[lsb ? i : int'(DW) - 1 - i] = mbits[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mbits.delete();
            mq.delete();
            started = 1'b1;
        end else if (started) begin
            m_acc = enb && bus.ser_vld && m_rdy() && !clr;
            m_pop = (mq.size() != 0) && bus.word_rdy;
            if (m_pop) void'(mq.pop_front());
            if (clr) begin
                mbits.delete();
            end else if (m_acc) begin
                mbits.push_back(bus.ser_in);
                if (mbits.size() == DW) begin
                    mq.push_back(assemble(lsb_first));
                    mbits.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            chk("ser_rdy", 32'(bus.ser_rdy), 32'(m_rdy()));
            chk("word_vld", 32'(bus.word_vld), 32'(mq.size() != 0));
            chk("busy", 32'(busy), 32'(mbits.size() != 0));
            if (mq.size() != 0) chk("word_out", 32'(bus.word_out), 32'(mq[0]));
            if (bus.word_vld && bus.word_rdy) popped.push_back(bus.word_out);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        bit got;
        int n;
        bus.ser_in  = b;
        bus.ser_vld = 1'b1;
        n = 0;
        forever begin
            #1;
            got = bus.ser_rdy && enb && !clr;
            cyc();
            if (got) break;
            n++;
            if (n > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.ser_vld = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit lsb);
        lsb_first = lsb;
        for (int i = 0; i < int'(DW); i++) begin
            send_bit(lsb ? w[i] : w[int'(DW) - 1 - i]);
        end
    endtask

    initial begin
        int n0;
        logic [7:0] gate_bits;
        rst = 1'b1; enb = 1'b0; clr = 1'b0; lsb_first = 1'b0;
        bus.ser_in = 1'b0; bus.ser_vld = 1'b0; bus.word_rdy = 1'b0;
        gate_bits = 8'b1101_1001;
        repeat (2) cyc();

        // Reset state
        chk("rst_ser_rdy_enb0", 32'(bus.ser_rdy), 32'd0);
        chk("rst_word_vld", 32'(bus.word_vld), 32'd0);
        chk("rst_word_out", 32'(bus.word_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0; enb = 1'b1;
        #1 chk("rst_ser_rdy_enb1", 32'(bus.ser_rdy), 32'd1);
        cyc();

        // MSB-first 1,0,1,1
        bus.word_rdy = 1'b1;
        send_word(4'hB, 1'b0);
        chk("msb_vld", 32'(bus.word_vld), 32'd1);
        chk("msb_word", 32'(bus.word_out), 32'hB);
        cyc();
        chk("msb_vld_one_cycle", 32'(bus.word_vld), 32'd0);

        // LSB-first 1,0,1,1 gives 4'b1101
        send_word(4'hD, 1'b1);
        chk("lsb_word", 32'(bus.word_out), 32'hD);
        cyc();

        // Back-to-back words
        n0 = popped.size();
        send_word(4'hA, 1'b0);
        send_word(4'h5, 1'b0);
        repeat (3) cyc();
        chk("b2b_count", 32'(popped.size() - n0), 32'd2);
        if (popped.size() >= n0 + 2) begin
            chk("b2b_first", 32'(popped[n0]), 32'hA);
            chk("b2b_second", 32'(popped[n0 + 1]), 32'h5);
        end

        // Backpressure: 3 and C fill the FIFO, 9 stalls on its last bit
        bus.word_rdy = 1'b0;
        n0 = popped.size();
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("bp_ser_rdy", 32'(bus.ser_rdy), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_head", 32'(bus.word_out), 32'h3);
        bus.word_rdy = 1'b1; bus.ser_in = 1'b1; bus.ser_vld = 1'b1;
        cyc();
        chk("bp_release", 32'(bus.ser_rdy), 32'd1);
        cyc();
        bus.ser_vld = 1'b0;
        repeat (3) cyc();
        chk("bp_count", 32'(popped.size() - n0), 32'd3);
        if (popped.size() >= n0 + 3) begin
            chk("bp_order0", 32'(popped[n0]), 32'h3);
            chk("bp_order1", 32'(popped[n0 + 1]), 32'hC);
            chk("bp_order2", 32'(popped[n0 + 2]), 32'h9);
        end

        // Abort with clr alongside a valid bit
        send_bit(1'b1); send_bit(1'b0);
        clr = 1'b1; bus.ser_in = 1'b1; bus.ser_vld = 1'b1;
        cyc();
        clr = 1'b0; bus.ser_vld = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        send_word(4'h6, 1'b0);
        chk("clr_word", 32'(bus.word_out), 32'h6);
        chk("clr_vld", 32'(bus.word_vld), 32'd1);
        cyc();

        // enb gating: only even cycles accepted -> bits 1,0,1,1
        bus.word_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enb = (i % 2 == 0);
            bus.ser_vld = 1'b1;
            bus.ser_in = gate_bits[i];
            cyc();
        end
        bus.ser_vld = 1'b0; enb = 1'b1;
        chk("enb_vld", 32'(bus.word_vld), 32'd1);
        chk("enb_word", 32'(bus.word_out), 32'hB);
        chk("enb_busy", 32'(busy), 32'd0);

        // Reset with FIFO full and a partial word
        send_word(4'h7, 1'b0);
        send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_vld", 32'(bus.word_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ser_rdy", 32'(bus.ser_rdy), 32'd1);
        bus.word_rdy = 1'b1;
        send_word(4'hE, 1'b0);
        chk("mid_rst_word", 32'(bus.word_out), 32'hE);
        cyc();

        // Random traffic; bit order only changes between words
        repeat (4000) begin
            enb          = ($urandom_range(0, 9) != 0);
            clr          = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            bus.ser_vld  = ($urandom_range(0, 9) < 7);
            bus.ser_in   = 1'($urandom_range(0, 1));
            bus.word_rdy = ($urandom_range(0, 1) == 1);
            if (mbits.size() == 0) lsb_first = 1'($urandom_range(0, 1));
            cyc();
        end
        rst = 1'b0; clr = 1'b0; bus.ser_vld = 1'b0;
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
